// File: rtl/spi_main.sv
// spi_main: SPI master for the 128-bit AES front-end subordinate.
// Full-duplex, MSB first, one word per cs-low frame, sclk idles low.
// sdi is launched on sclk rising edges; sdo is captured as sclk falls.
// Optional build macro SPI_CS_GAP_EN: hold cs high for CS_GAP extra cycles
// after every frame (GAP state) so the subordinate can re-arm its counters.
module spi_main #(
   parameter int DATA_WIDTH = 128,
   parameter int CLK_DIV    = 2,
   parameter int CS_GAP     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  done,
   output logic                  cs,
   output logic                  sclk,
   output logic                  sdi,
   input  logic                  sdo
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   // Reject parameter sets the frame timing cannot honour.
   if ((CLK_DIV < 1) || (CS_GAP < 1) || (DATA_WIDTH < 2)) begin : g_param_check
      $error("spi_main: CLK_DIV and CS_GAP must be >= 1, DATA_WIDTH >= 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_FINISH
`ifdef SPI_CS_GAP_EN
      , ST_GAP
`endif
   } state_t;

   state_t                state_q;
   logic [DIV_W-1:0]      div_cnt_q;
   logic [BIT_W-1:0]      bit_cnt_q;
   logic [DATA_WIDTH-1:0] tx_sh_q;
   logic [DATA_WIDTH-1:0] rx_sh_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  cs_q;
   logic                  sclk_q;
   logic                  sdi_q;
`ifdef SPI_CS_GAP_EN
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
   logic [GAP_W-1:0]      gap_cnt_q;
`endif

   logic div_end;
   logic in_timed_state;

   assign div_end        = (div_cnt_q == DIV_LAST);
   assign in_timed_state = (state_q == ST_SETUP) || (state_q == ST_HIGH) ||
                           (state_q == ST_LOW)   || (state_q == ST_FINISH);

   assign rx_data = rx_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cs      = cs_q;
   assign sclk    = sclk_q;
   assign sdi     = sdi_q;

   // Frame sequencer: phase timing, serial shifting and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b0;
         sdi_q     <= 1'b0;
`ifdef SPI_CS_GAP_EN
         gap_cnt_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;

         // Every sclk half-period lasts CLK_DIV clk cycles.
         if (in_timed_state) begin
            div_cnt_q <= div_end ? '0 : div_cnt_q + 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  tx_sh_q   <= tx_data;
                  sdi_q     <= tx_data[DATA_WIDTH-1];
                  cs_q      <= 1'b0;
                  bit_cnt_q <= '0;
                  div_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (div_end) begin
                  sclk_q  <= 1'b1;
                  state_q <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (div_end) begin
                  sclk_q    <= 1'b0;
                  rx_sh_q   <= {rx_sh_q[DATA_WIDTH-2:0], sdo};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  state_q   <= (bit_cnt_q == BIT_LAST) ? ST_FINISH : ST_LOW;
               end
            end
            ST_LOW: begin
               // sdi moves only together with the rising sclk edge.
               if (div_end) begin
                  sclk_q  <= 1'b1;
                  sdi_q   <= tx_sh_q[DATA_WIDTH-2];
                  tx_sh_q <= {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                  state_q <= ST_HIGH;
               end
            end
            ST_FINISH: begin
               if (div_end) begin
                  cs_q      <= 1'b1;
                  rx_data_q <= rx_sh_q;
                  done_q    <= 1'b1;
`ifdef SPI_CS_GAP_EN
                  gap_cnt_q <= '0;
                  state_q   <= ST_GAP;
`else
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
`endif
               end
            end
`ifdef SPI_CS_GAP_EN
            ST_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_main.sv
// tb_spi_main: directed checks of spi_main at DATA_WIDTH=128, CLK_DIV=2.
// sdo is either looped back from sdi or driven by a behavioural subordinate
// that presents bit k of its word on the k-th sclk rising edge.
module tb_spi_main;

   localparam int DW = 128;
   localparam int FRAME_CS_LOW = 514;
`ifdef SPI_CS_GAP_EN
   localparam int EXP_GAP        = 5;
   localparam int EXP_BUSY_AFTER = 4;
`else
   localparam int EXP_GAP        = 1;
   localparam int EXP_BUSY_AFTER = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic [DW-1:0] rx_data;
   logic          busy;
   logic          done;
   logic          cs;
   logic          sclk;
   logic          sdi;
   logic          sdo;

   int total = 0;
   int bad   = 0;

   // monitor state
   int            cs_low_n = 0;
   int            rise_n = 0;
   int            fall_n = 0;
   int            done_n = 0;
   int            sdi_bad = 0;
   int            high_run = 0;
   int            gap_n = 0;
   int            gap_log [0:7];
   logic          sclk_p = 1'b0;
   logic          cs_p = 1'b1;
   logic          sdi_p = 1'b0;

   // subordinate model
   logic          loop_mode = 1'b1;
   logic [DW-1:0] model_word = '0;
   logic [DW-1:0] cap = '0;
   logic          sdo_m = 1'b0;
   int            mrise = 0;

   assign sdo = loop_mode ? sdi : sdo_m;

   spi_main dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tx_data (tx_data),
      .rx_data (rx_data),
      .busy    (busy),
      .done    (done),
      .cs      (cs),
      .sclk    (sclk),
      .sdi     (sdi),
      .sdo     (sdo)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!cs) cs_low_n++;
      if (sclk && !sclk_p) rise_n++;
      if (!sclk && sclk_p) fall_n++;
      if (done === 1'b1) done_n++;
      if (!cs && !cs_p && (sdi !== sdi_p) && !(sclk && !sclk_p)) sdi_bad++;
      if (cs) begin
         high_run++;
      end else begin
         if (cs_p && gap_n < 8) begin
            gap_log[gap_n] = high_run;
            gap_n++;
         end
         high_run = 0;
      end
      sclk_p = sclk;
      cs_p   = cs;
      sdi_p  = sdi;
   end

   always @(posedge sclk) begin
      if (mrise < DW) sdo_m <= model_word[DW-1-mrise];
      mrise++;
   end

   always @(negedge sclk) begin
      if (!cs) cap = {cap[DW-2:0], sdi};
   end

   task automatic clear_mon();
      @(posedge clk);
      cs_low_n = 0; rise_n = 0; fall_n = 0; done_n = 0; sdi_bad = 0;
      gap_n = 0; high_run = 0; cap = '0; mrise = 0;
   endtask

   task automatic wait_done(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk); #1;
         if (done_n >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_start(input logic [DW-1:0] w);
      @(negedge clk);
      tx_data = w;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (cs !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b exp=1", cs); end
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
      total++; if (sdi !== 1'b0) begin bad++; $display("FAIL reset_sdi got=%b exp=0", sdi); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (rx_data !== '0) begin bad++; $display("FAIL reset_rx got=%h exp=0", rx_data); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (cs !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset cs=%b busy=%b exp cs=1 busy=0", cs, busy); end
      $display("test_reset: checked outputs under and after reset");
   endtask

   task automatic test_basic();
      logic [DW-1:0] w;
      bit ok;
      w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      loop_mode = 1'b1;
      clear_mon();
      pulse_start(w);
      wait_done(1, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=none exp=done"); end
      repeat (20) @(negedge clk);
      total++; if (cs_low_n != FRAME_CS_LOW) begin bad++; $display("FAIL basic_cs_low got=%0d exp=%0d", cs_low_n, FRAME_CS_LOW); end
      total++; if (rise_n != DW) begin bad++; $display("FAIL basic_sclk_rises got=%0d exp=%0d", rise_n, DW); end
      total++; if (fall_n != DW) begin bad++; $display("FAIL basic_sclk_falls got=%0d exp=%0d", fall_n, DW); end
      total++; if (done_n != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_n); end
      total++; if (rx_data !== w) begin bad++; $display("FAIL basic_rx got=%h exp=%h", rx_data, w); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
      $display("test_basic: tx=%h rx=%h cs_low=%0d rises=%0d", w, rx_data, cs_low_n, rise_n);
   endtask

   task automatic test_serial_order();
      logic [DW-1:0] w;
      logic [DW-1:0] m;
      bit ok;
      w = 128'hC0FFEE00_DEADBEEF_12345678_9ABCDEF0;
      m = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
      model_word = m;
      loop_mode = 1'b0;
      clear_mon();
      pulse_start(w);
      wait_done(1, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL order_done_timeout got=none exp=done"); end
      repeat (5) @(negedge clk);
      total++; if (cap !== w) begin bad++; $display("FAIL order_sdi_msb_first got=%h exp=%h", cap, w); end
      total++; if (sdi_bad != 0) begin bad++; $display("FAIL order_sdi_change got=%0d exp=0", sdi_bad); end
      total++; if (rx_data !== m) begin bad++; $display("FAIL order_rx got=%h exp=%h", rx_data, m); end
      loop_mode = 1'b1;
      $display("test_serial_order: sub_saw=%h rx=%h bad_sdi_edges=%0d", cap, rx_data, sdi_bad);
   endtask

   task automatic test_start_during_busy();
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      bit ok;
      a = 128'h0F0F0F0F_11111111_22222222_33333333;
      b = 128'hF0F0F0F0_EEEEEEEE_DDDDDDDD_CCCCCCCC;
      loop_mode = 1'b1;
      clear_mon();
      pulse_start(a);
      repeat (100) @(negedge clk);
      tx_data = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL busy_start_timeout got=none exp=done"); end
      repeat (600) @(negedge clk);
      total++; if (done_n != 1) begin bad++; $display("FAIL busy_start_done_count got=%0d exp=1", done_n); end
      total++; if (rx_data !== a) begin bad++; $display("FAIL busy_start_rx got=%h exp=%h", rx_data, a); end
      total++; if (cs_low_n != FRAME_CS_LOW) begin bad++; $display("FAIL busy_start_cs_low got=%0d exp=%0d", cs_low_n, FRAME_CS_LOW); end
      $display("test_start_during_busy: dones=%0d rx=%h", done_n, rx_data);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w;
      bit ok;
      int busy_after;
      w = 128'h5A5A5A5A_A5A5A5A5_01234567_89ABCDEF;
      loop_mode = 1'b1;
      clear_mon();
      @(negedge clk);
      tx_data = w;
      start = 1'b1;
      wait_done(1, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout got=none exp=done"); end
      busy_after = 0;
      while (busy === 1'b1 && busy_after < 20) begin
         busy_after++;
         @(negedge clk); #1;
      end
      total++; if (busy_after != EXP_BUSY_AFTER) begin bad++; $display("FAIL b2b_busy_after_done got=%0d exp=%0d", busy_after, EXP_BUSY_AFTER); end
      wait_done(3, 4000, ok);
      start = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL b2b_third_timeout got=none exp=done"); end
      repeat (30) @(negedge clk);
      total++; if (done_n != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", done_n); end
      total++; if (gap_n != 3) begin bad++; $display("FAIL b2b_frames got=%0d exp=3", gap_n); end
      total++; if (gap_log[1] != EXP_GAP) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=%0d", gap_log[1], EXP_GAP); end
      total++; if (gap_log[2] != EXP_GAP) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=%0d", gap_log[2], EXP_GAP); end
      total++; if (cs_low_n != 3 * FRAME_CS_LOW) begin bad++; $display("FAIL b2b_cs_low got=%0d exp=%0d", cs_low_n, 3 * FRAME_CS_LOW); end
      total++; if (rx_data !== w) begin bad++; $display("FAIL b2b_rx got=%h exp=%h", rx_data, w); end
      $display("test_back_to_back: frames=%0d gaps=%0d,%0d busy_after_done=%0d", done_n, gap_log[1], gap_log[2], busy_after);
   endtask

   task automatic test_reset_mid_frame();
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      bit ok;
      a = 128'hFEDCBA98_76543210_FEDCBA98_76543210;
      b = 128'h13579BDF_2468ACE0_0ECA8642_FDB97531;
      loop_mode = 1'b1;
      clear_mon();
      pulse_start(a);
      repeat (199) @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (cs !== 1'b1) begin bad++; $display("FAIL midrst_cs got=%b exp=1", cs); end
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL midrst_sclk got=%b exp=0", sclk); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      total++; if (rx_data !== '0) begin bad++; $display("FAIL midrst_rx got=%h exp=0", rx_data); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      total++; if (done_n != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", done_n); end
      clear_mon();
      pulse_start(b);
      wait_done(1, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL midrst_next_timeout got=none exp=done"); end
      repeat (5) @(negedge clk);
      total++; if (rx_data !== b) begin bad++; $display("FAIL midrst_next_rx got=%h exp=%h", rx_data, b); end
      total++; if (cs_low_n != FRAME_CS_LOW) begin bad++; $display("FAIL midrst_next_cs_low got=%0d exp=%0d", cs_low_n, FRAME_CS_LOW); end
      $display("test_reset_mid_frame: aborted frame, next rx=%h", rx_data);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_serial_order();
      test_start_during_busy();
      test_back_to_back();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_main.md
Name: spi_main

Overview:
- SPI master that drives the 128-bit SPI subordinate in front of the AES core.
- Accepts a parallel word and a start pulse on the system clock, generates cs/sclk/sdi, and captures the subordinate's sdo into a parallel word.
- Full-duplex, MSB first, one word per cs-low frame.
- sclk idles low. The subordinate samples sdi on sclk falling edges and updates sdo on sclk rising edges.

Parameters:
- DATA_WIDTH, 128, bits per frame; must match the subordinate.
- CLK_DIV, 2, clk cycles per sclk half-period; must be >= 1.
- CS_GAP, 4, minimum clk cycles cs stays high between frames; used only with SPI_CS_GAP_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a frame; sampled only when busy=0.
- tx_data  input  DATA_WIDTH  word to send; latched on start acceptance.
- rx_data  output  DATA_WIDTH  word received in the last completed frame.
- busy  output  1  high from the cycle after start acceptance until the frame (and gap, if enabled) ends.
- done  output  1  one-cycle pulse when a frame completes.
- cs  output  1  chip select, active low.
- sclk  output  1  serial clock, registered.
- sdi  output  1  serial data to the subordinate, registered.
- sdo  input  1  serial data from the subordinate.

Behaviour:
- Reset values (async, rst=1): cs=1, sclk=0, sdi=0, busy=0, done=0, rx_data=0. Internal state: state=IDLE, counters=0, shift registers=0.
- States: IDLE, SETUP, HIGH, LOW, FINISH, GAP (GAP only with the macro).
- div_cnt counts 0..CLK_DIV-1 inside each of SETUP, HIGH, LOW, FINISH. The state advances on the cycle div_cnt==CLK_DIV-1, and div_cnt then resets to 0.
- IDLE, start=1: latch tx_data into tx_sh; cs<=0; sdi<=tx_data[DATA_WIDTH-1]; bit_cnt<=0; busy<=1; go to SETUP.
- IDLE, start=0: nothing changes.
- SETUP end: sclk<=1; go to HIGH.
- HIGH end:
  - sclk<=0 (falling edge).
  - Capture into rx_sh: rx_sh<={rx_sh[DATA_WIDTH-2:0], sdo}.
  - bit_cnt<=bit_cnt+1.
  - If bit_cnt==DATA_WIDTH-1, go to FINISH; else go to LOW.
- LOW end:
  - sclk<=1.
  - Shift tx_sh left by one; sdi<=next bit, i.e. tx_sh[DATA_WIDTH-2] before the shift.
  - Go to HIGH.
  - sdi only changes with a rising sclk, so it is stable through each falling edge.
- FINISH end:
  - cs<=1; rx_data<=final rx_sh value, including the last captured bit; done<=1 for exactly one cycle.
  - Without the macro: busy<=0 and go to IDLE.
- Frame timing: cs is low for CLK_DIV*(2*DATA_WIDTH+1) clk cycles, which is 514 at the defaults. Exactly DATA_WIDTH sclk rising and falling edges occur per frame.
- start while busy=1 is ignored; no queuing. tx_data changes during a frame have no effect.
- The cycle done is asserted is the first cycle a new start may be accepted (without the macro). A start in that cycle begins the next frame with cs=1 held for exactly one cycle.
- sdo is sampled only at the HIGH-end edge, never at any other time.
- Reset asserted mid-frame: cs immediately 1, sclk 0; the frame is aborted; no done pulse; rx_data cleared to 0.
- bit_cnt width: clog2(DATA_WIDTH)+1, with no wrap within a frame. div_cnt width: clog2(CLK_DIV), minimum 1.

Optional Feature:
- Macro: SPI_CS_GAP_EN.
- With the macro:
  - FINISH end raises cs and pulses done, but busy stays 1 and the FSM enters GAP.
  - GAP counts CS_GAP clk cycles with cs=1 and sclk=0, then busy<=0 and the FSM returns to IDLE.
  - start is ignored throughout GAP.
  - This guarantees cs high for at least CS_GAP+1 cycles, which gives the subordinate time to reset its counters.
- Without the macro: no GAP state; the CS_GAP parameter is unused.

Test Plan:
- Basic frame, CLK_DIV=2, DATA_WIDTH=128, sdo tied to sdi:
  - Stimulus: start pulse with tx_data=128'h00112233_44556677_8899AABB_CCDDEEFF.
  - Required: cs low for exactly 514 cycles; 128 sclk rising edges; done single pulse; rx_data=tx_data.
- Serial order, behavioural subordinate model returning 128'hFFFF0000_...:
  - Required: sdi bit order MSB first; sdi changes only at sclk rising edges; rx_data equals the model word.
- Start during busy:
  - Stimulus: second start 100 cycles into a frame with different tx_data.
  - Required: ignored; only one done; rx_data from the first frame.
- Back-to-back (no macro):
  - Stimulus: start held high continuously.
  - Required: consecutive frames with cs high for exactly 1 cycle between them; done once per frame.
- Reset mid-frame:
  - Stimulus: assert rst at cycle 200 of a frame.
  - Required: cs=1, sclk=0, busy=0, rx_data=0 asynchronously; no done; the next start produces a correct full frame.
- SPI_CS_GAP_EN defined, CS_GAP=4, start held high:
  - Required: busy stays 1 for 4 cycles after done; cs high for 5 cycles between frames.
